// File: rtl/writeback_arbiter_if.sv
// Writeback port bundle: ALU and load result sources, register-file write
// port, forwarding lookups and buffer occupancy.
interface writeback_arbiter_if #(parameter int N = 32);
   logic         Alu_Write_i;
   logic [4:0]   Alu_Register_i;
   logic [N-1:0] Alu_Data_i;
   logic         Load_Valid_i;
   logic [4:0]   Load_Register_i;
   logic [N-1:0] Load_Data_i;
   logic         Load_Ready_o;
   logic         Reg_Write_o;
   logic [4:0]   Write_Register_o;
   logic [N-1:0] Write_Data_o;
   logic [4:0]   Fwd_Register_1_i;
   logic [4:0]   Fwd_Register_2_i;
   logic         Fwd_Hit_1_o;
   logic         Fwd_Hit_2_o;
   logic [N-1:0] Fwd_Data_1_o;
   logic [N-1:0] Fwd_Data_2_o;
   logic [1:0]   Pending_o;

   modport slave (
      input  Alu_Write_i, Alu_Register_i, Alu_Data_i,
      input  Load_Valid_i, Load_Register_i, Load_Data_i,
      output Load_Ready_o,
      output Reg_Write_o, Write_Register_o, Write_Data_o,
      input  Fwd_Register_1_i, Fwd_Register_2_i,
      output Fwd_Hit_1_o, Fwd_Hit_2_o, Fwd_Data_1_o, Fwd_Data_2_o,
      output Pending_o
   );

   modport master (
      output Alu_Write_i, Alu_Register_i, Alu_Data_i,
      output Load_Valid_i, Load_Register_i, Load_Data_i,
      input  Load_Ready_o,
      input  Reg_Write_o, Write_Register_o, Write_Data_o,
      output Fwd_Register_1_i, Fwd_Register_2_i,
      input  Fwd_Hit_1_o, Fwd_Hit_2_o, Fwd_Data_1_o, Fwd_Data_2_o,
      input  Pending_o
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges single-cycle ALU results and handshaked load results onto one
// register-file write port, with a 2-entry load buffer and forwarding lookup.
module writeback_arbiter #(parameter int N = 32) (
   input logic             clk,
   input logic             reset,
   writeback_arbiter_if.slave wb
);

   logic [1:0]   count;
   logic [4:0]   buf_reg  [2];
   logic [N-1:0] buf_data [2];
   logic         rst_q;
   logic         out_valid;
   logic [4:0]   out_reg;
   logic [N-1:0] out_data;

   logic         ready, alu_live, accept, load_live;
   logic         have0, have1, kill0, kill1, pop, direct, push, keep0, keep1;
   logic         nxt_valid;
   logic [4:0]   nxt_reg, nxt_reg0, nxt_reg1;
   logic [N-1:0] nxt_data, nxt_data0, nxt_data1;
   logic [1:0]   nxt_count;

   logic [4:0]   fwd_addr [2];
   logic         fwd_hit  [2];
   logic [N-1:0] fwd_data [2];

   // rst_q holds ready low for the cycle following a reset edge
   assign ready = ~rst_q & (count != 2'd2);

   always_comb begin
      alu_live  = wb.Alu_Write_i & (wb.Alu_Register_i != '0);
      accept    = wb.Load_Valid_i & ready;
      // A same-cycle ALU write to the same register is younger, so the load dies
      load_live = accept & (wb.Load_Register_i != '0) &
                  ~(alu_live & (wb.Load_Register_i == wb.Alu_Register_i));
      have0     = (count != 2'd0);
      have1     = (count == 2'd2);
      kill0     = alu_live & (buf_reg[0] == wb.Alu_Register_i);
      kill1     = alu_live & (buf_reg[1] == wb.Alu_Register_i);
      pop       = ~alu_live & have0;
      direct    = ~alu_live & ~have0 & load_live;
      push      = load_live & ~direct;
      keep0     = have0 & ~kill0 & ~pop;
      keep1     = have1 & ~kill1;

      nxt_valid = alu_live | pop | direct;
      nxt_reg   = '0;
      nxt_data  = '0;
      if (alu_live) begin
         nxt_reg  = wb.Alu_Register_i;
         nxt_data = wb.Alu_Data_i;
      end else if (pop) begin
         nxt_reg  = buf_reg[0];
         nxt_data = buf_data[0];
      end else if (direct) begin
         nxt_reg  = wb.Load_Register_i;
         nxt_data = wb.Load_Data_i;
      end

      // Compact survivors toward the head, then append the new load
      if (keep0) begin
         nxt_reg0  = buf_reg[0];
         nxt_data0 = buf_data[0];
      end else if (keep1) begin
         nxt_reg0  = buf_reg[1];
         nxt_data0 = buf_data[1];
      end else begin
         nxt_reg0  = wb.Load_Register_i;
         nxt_data0 = wb.Load_Data_i;
      end
      if (keep0 & keep1) begin
         nxt_reg1  = buf_reg[1];
         nxt_data1 = buf_data[1];
      end else begin
         nxt_reg1  = wb.Load_Register_i;
         nxt_data1 = wb.Load_Data_i;
      end
      nxt_count = {1'b0, keep0} + {1'b0, keep1} + {1'b0, push};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rst_q       <= 1'b1;
         count       <= '0;
         out_valid   <= 1'b0;
         out_reg     <= '0;
         out_data    <= '0;
         buf_reg[0]  <= '0;
         buf_reg[1]  <= '0;
         buf_data[0] <= '0;
         buf_data[1] <= '0;
      end else begin
         rst_q       <= 1'b0;
         count       <= nxt_count;
         out_valid   <= nxt_valid;
         out_reg     <= nxt_reg;
         out_data    <= nxt_data;
         buf_reg[0]  <= nxt_reg0;
         buf_reg[1]  <= nxt_reg1;
         buf_data[0] <= nxt_data0;
         buf_data[1] <= nxt_data1;
      end
   end

   assign fwd_addr[0] = wb.Fwd_Register_1_i;
   assign fwd_addr[1] = wb.Fwd_Register_2_i;

   // Tail entry is the youngest buffered load when two are held
   always_comb begin
      for (int unsigned k = 0; k < 2; k++) begin
         fwd_hit[k]  = 1'b0;
         fwd_data[k] = '0;
         if (fwd_addr[k] != '0) begin
            if ((count == 2'd2) && (buf_reg[1] == fwd_addr[k])) begin
               fwd_hit[k]  = 1'b1;
               fwd_data[k] = buf_data[1];
            end else if ((count != 2'd0) && (buf_reg[0] == fwd_addr[k])) begin
               fwd_hit[k]  = 1'b1;
               fwd_data[k] = buf_data[0];
            end else if (out_valid && (out_reg == fwd_addr[k])) begin
               fwd_hit[k]  = 1'b1;
               fwd_data[k] = out_data;
            end
         end
      end
   end

   assign wb.Load_Ready_o     = ready;
   assign wb.Reg_Write_o      = out_valid;
   assign wb.Write_Register_o = out_reg;
   assign wb.Write_Data_o     = out_data;
   assign wb.Fwd_Hit_1_o      = fwd_hit[0];
   assign wb.Fwd_Hit_2_o      = fwd_hit[1];
   assign wb.Fwd_Data_1_o     = fwd_data[0];
   assign wb.Fwd_Data_2_o     = fwd_data[1];
   assign wb.Pending_o        = count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a scoreboard queue holds the expected
// register-file writes in order; a negedge monitor pops and compares them.
module tb_writeback_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   logic [36:0] exp_q [$];

   writeback_arbiter_if #(.N(32)) wb ();

   writeback_arbiter #(.N(32)) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      wb.Alu_Write_i      = 1'b0;
      wb.Alu_Register_i   = '0;
      wb.Alu_Data_i       = '0;
      wb.Load_Valid_i     = 1'b0;
      wb.Load_Register_i  = '0;
      wb.Load_Data_i      = '0;
      wb.Fwd_Register_1_i = '0;
      wb.Fwd_Register_2_i = '0;
   endtask

   task automatic alu(input logic [4:0] r, input logic [31:0] d);
      wb.Alu_Write_i    = 1'b1;
      wb.Alu_Register_i = r;
      wb.Alu_Data_i     = d;
   endtask

   task automatic load(input logic [4:0] r, input logic [31:0] d);
      wb.Load_Valid_i    = 1'b1;
      wb.Load_Register_i = r;
      wb.Load_Data_i     = d;
   endtask

   // Every register-file write must be the next one the scoreboard expects
   always @(negedge clk) begin
      if (wb.Reg_Write_o === 1'b1) begin
         chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0)
            chk("write_order", {27'b0, wb.Write_Register_o, wb.Write_Data_o},
                {27'b0, exp_q.pop_front()});
      end
   end

   initial begin
      reset = 1'b1;
      clear();
      tick();
      tick();
      chk("rst_write",   64'(wb.Reg_Write_o),      64'd0);
      chk("rst_wreg",    64'(wb.Write_Register_o), 64'd0);
      chk("rst_wdata",   64'(wb.Write_Data_o),     64'd0);
      chk("rst_pending", 64'(wb.Pending_o),        64'd0);
      chk("rst_ready",   64'(wb.Load_Ready_o),     64'd0);
      reset = 1'b0;
      tick();
      chk("ready_after_rst", 64'(wb.Load_Ready_o), 64'd1);
      wb.Fwd_Register_1_i = 5'd9;
      #1;
      chk("fwd_miss_hit",  64'(wb.Fwd_Hit_1_o),  64'd0);
      chk("fwd_miss_data", 64'(wb.Fwd_Data_1_o), 64'd0);

      // Lone load goes straight to the output stage
      clear();
      load(5'd5, 32'hA5A5_A5A5);
      exp_q.push_back({5'd5, 32'hA5A5_A5A5});
      tick();
      clear();
      chk("lone_write",   64'(wb.Reg_Write_o),      64'd1);
      chk("lone_wreg",    64'(wb.Write_Register_o), 64'd5);
      chk("lone_wdata",   64'(wb.Write_Data_o),     64'hA5A5_A5A5);
      chk("lone_pending", 64'(wb.Pending_o),        64'd0);
      tick();

      // ALU beats a same-cycle load; the load follows a cycle later
      alu(5'd3, 32'h11);
      load(5'd4, 32'h22);
      exp_q.push_back({5'd3, 32'h11});
      exp_q.push_back({5'd4, 32'h22});
      tick();
      clear();
      chk("pair_wreg1",    64'(wb.Write_Register_o), 64'd3);
      chk("pair_pending1", 64'(wb.Pending_o),        64'd1);
      tick();
      chk("pair_wreg2",    64'(wb.Write_Register_o), 64'd4);
      chk("pair_wdata2",   64'(wb.Write_Data_o),     64'h22);
      chk("pair_pending2", 64'(wb.Pending_o),        64'd0);
      tick();

      // Three ALU writes with loads offered throughout: only two loads fit
      exp_q.push_back({5'd10, 32'h100});
      exp_q.push_back({5'd11, 32'h101});
      exp_q.push_back({5'd12, 32'h102});
      exp_q.push_back({5'd20, 32'h200});
      exp_q.push_back({5'd21, 32'h201});
      alu(5'd10, 32'h100);
      load(5'd20, 32'h200);
      tick();
      chk("burst_pend1",  64'(wb.Pending_o),    64'd1);
      chk("burst_ready1", 64'(wb.Load_Ready_o), 64'd1);
      alu(5'd11, 32'h101);
      load(5'd21, 32'h201);
      tick();
      chk("burst_pend2",  64'(wb.Pending_o),    64'd2);
      chk("burst_ready2", 64'(wb.Load_Ready_o), 64'd0);
      alu(5'd12, 32'h102);
      load(5'd22, 32'h202);
      tick();
      chk("burst_pend3",  64'(wb.Pending_o),    64'd2);
      chk("burst_ready3", 64'(wb.Load_Ready_o), 64'd0);
      clear();
      tick();
      chk("drain_pend1", 64'(wb.Pending_o),        64'd1);
      chk("drain_wreg1", 64'(wb.Write_Register_o), 64'd20);
      chk("drain_data1", 64'(wb.Write_Data_o),     64'h200);
      tick();
      chk("drain_pend0", 64'(wb.Pending_o),        64'd0);
      chk("drain_wreg2", 64'(wb.Write_Register_o), 64'd21);
      tick();

      // Buffered load to r7 is killed by a younger ALU write to r7
      alu(5'd8, 32'h8);
      load(5'd7, 32'h1);
      exp_q.push_back({5'd8, 32'h8});
      exp_q.push_back({5'd7, 32'h2});
      tick();
      clear();
      chk("kill_pend1", 64'(wb.Pending_o), 64'd1);
      alu(5'd7, 32'h2);
      wb.Fwd_Register_1_i = 5'd7;
      wb.Fwd_Register_2_i = 5'd8;
      #1;
      chk("fwd_buf_hit",   64'(wb.Fwd_Hit_1_o),  64'd1);
      chk("fwd_buf_data",  64'(wb.Fwd_Data_1_o), 64'h1);
      chk("fwd_out_hit2",  64'(wb.Fwd_Hit_2_o),  64'd1);
      chk("fwd_out_data2", 64'(wb.Fwd_Data_2_o), 64'h8);
      tick();
      chk("kill_pend0",    64'(wb.Pending_o),    64'd0);
      chk("kill_fwd_hit",  64'(wb.Fwd_Hit_1_o),  64'd1);
      chk("kill_fwd_data", 64'(wb.Fwd_Data_1_o), 64'h2);
      clear();
      tick();

      // Writes to r0 are dropped and r0 never forwards
      alu(5'd0, 32'hBEEF);
      load(5'd0, 32'hDEAD);
      wb.Fwd_Register_1_i = 5'd0;
      #1;
      chk("r0_fwd_hit", 64'(wb.Fwd_Hit_1_o), 64'd0);
      tick();
      clear();
      chk("r0_write1",  64'(wb.Reg_Write_o), 64'd0);
      chk("r0_pending", 64'(wb.Pending_o),   64'd0);
      tick();
      chk("r0_write2",  64'(wb.Reg_Write_o), 64'd0);

      // Reset with a full buffer discards both buffered loads
      alu(5'd1, 32'h31);
      load(5'd21, 32'h41);
      exp_q.push_back({5'd1, 32'h31});
      exp_q.push_back({5'd2, 32'h32});
      tick();
      alu(5'd2, 32'h32);
      load(5'd22, 32'h42);
      tick();
      clear();
      chk("pre_rst_pending", 64'(wb.Pending_o), 64'd2);
      reset = 1'b1;
      tick();
      chk("mid_rst_write",   64'(wb.Reg_Write_o),  64'd0);
      chk("mid_rst_pending", 64'(wb.Pending_o),    64'd0);
      chk("mid_rst_ready",   64'(wb.Load_Ready_o), 64'd0);
      reset = 1'b0;
      tick();
      chk("post_rst_ready",   64'(wb.Load_Ready_o), 64'd1);
      chk("post_rst_pending", 64'(wb.Pending_o),    64'd0);
      chk("post_rst_write",   64'(wb.Reg_Write_o),  64'd0);
      repeat (4) tick();

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, giving the data width of every write and forward data port.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Alu_Write_i, input, 1 bit: single-cycle ALU result valid this cycle, no backpressure.
REQ-005 SHALL have port Alu_Register_i, input, 5 bits: ALU destination register.
REQ-006 SHALL have port Alu_Data_i, input, N bits: ALU result.
REQ-007 SHALL have port Load_Valid_i, input, 1 bit: load/multicycle result offered.
REQ-008 SHALL have port Load_Register_i, input, 5 bits: load destination register.
REQ-009 SHALL have port Load_Data_i, input, N bits: load result.
REQ-010 SHALL have port Load_Ready_o, output, 1 bit: load result accepted when Load_Valid_i and Load_Ready_o are both high at a clock edge.
REQ-011 SHALL have port Reg_Write_o, output, 1 bit: register-file write enable.
REQ-012 SHALL have port Write_Register_o, output, 5 bits: register-file write address.
REQ-013 SHALL have port Write_Data_o, output, N bits: register-file write data.
REQ-014 SHALL have ports Fwd_Register_1_i and Fwd_Register_2_i, input, 5 bits each: read addresses to check against pending writes.
REQ-015 SHALL have ports Fwd_Hit_1_o and Fwd_Hit_2_o, output, 1 bit each: a pending write matches the corresponding read address.
REQ-016 SHALL have ports Fwd_Data_1_o and Fwd_Data_2_o, output, N bits each: youngest pending data for the corresponding read address.
REQ-017 SHALL have port Pending_o, output, 2 bits: number of occupied entries in the load buffer (0 to 2).

Function
REQ-018 SHALL drive Reg_Write_o, Write_Register_o and Write_Data_o from an output register stage, so a write appears on the register-file port exactly one cycle after it is selected.
REQ-019 SHALL select one write per cycle for the output stage in this priority: ALU write to a nonzero register first; else the head of the load buffer; else a load accepted this cycle while the buffer is empty.
REQ-020 SHALL load the output stage with Reg_Write_o=0 when nothing is selected.
REQ-021 SHALL hold a 2-entry FIFO for accepted loads that are not selected in their acceptance cycle, and SHALL retire those loads in acceptance order.
REQ-022 SHALL drive Load_Ready_o = (registered count < 2); a full buffer that pops this cycle still reports Load_Ready_o=0 that cycle.
REQ-023 SHALL drop any write to register 0: an ALU write to register 0 leaves the port free for the buffer, and a load to register 0 is accepted, not buffered and never written.
REQ-024 SHALL treat an accepted ALU write as younger than every load that is buffered or accepted in the same cycle.
REQ-025 SHALL invalidate, on an accepted ALU write to register R (R≠0), every buffered entry with register R and any same-cycle accepted load to R; invalidated entries are removed and Pending_o drops accordingly.
REQ-026 SHALL compute Fwd_Hit_k/Fwd_Data_k combinationally from the buffer tail, then the buffer head, then the output stage (Reg_Write_o=1), in that priority; register 0 never hits and a miss drives Fwd_Data_k = 0.
REQ-027 SHALL, when the buffer is full (Load_Ready_o=0) and Alu_Write_i=1, issue the ALU write, keep the buffer intact apart from REQ-025 kills, and not accept the load.

Reset
REQ-028 SHALL, while reset is high at a clock edge, clear the output stage (Reg_Write_o=0, Write_Register_o=0, Write_Data_o=0), empty the buffer (Pending_o=0) and force Load_Ready_o=0.
REQ-029 SHALL raise Load_Ready_o=1 in the first cycle after reset deasserts.
REQ-030 SHALL discard any in-flight or buffered write when reset is asserted mid-operation, so that none reaches the register-file port.

Verification
REQ-031 Bench SHALL check: a lone load to r5 with data 0xA5A5A5A5 → next cycle Reg_Write_o=1, Write_Register_o=5, Write_Data_o=0xA5A5A5A5, Pending_o=0.
REQ-032 Bench SHALL check: an ALU write to r3 (0x11) in the same cycle as a load to r4 (0x22) → r3 is written at t+1, r4 at t+2, and Pending_o=1 at t+1.
REQ-033 Bench SHALL check: 3 back-to-back ALU writes plus continuous load valid → 2 loads accepted, Load_Ready_o=0 with Pending_o=2, then loads drain in order after the ALU writes stop.
REQ-034 Bench SHALL check: load r7=0x1 buffered, then an ALU write r7=0x2 → the only write to r7 is 0x2, and Fwd_Register_1_i=7 gives Hit=1, Data=0x2.
REQ-035 Bench SHALL check: a load to r0 and an ALU write to r0 → Reg_Write_o never rises and Fwd_Register_1_i=0 gives Hit=0.
REQ-036 Bench SHALL check: reset asserted while Pending_o=2 → next cycle Reg_Write_o=0, Pending_o=0, Load_Ready_o=0, and no buffered write appears afterwards.
